// File: rtl/bt_hdr_tx_seq_pkg.sv
// ----------------------------------------------------------------------------
// bt_hdr_tx_seq_pkg
// Shared constants and types for the Bluetooth packet-header transmit
// sequencer.
//   HDR_BITS : header payload bits (LT_ADDR, TYPE, FLOW, ARQN, SEQN)
//   HEC_BITS : header error check bits
//   REP      : rate-1/3 repetition factor per logical bit
//   state_t  : sequencer FSM states
// ----------------------------------------------------------------------------
package bt_hdr_tx_seq_pkg;

    localparam int HDR_BITS = 10;
    localparam int HEC_BITS = 8;
    localparam int REP      = 3;

    // The bit index must cover the longer of the two phases (header).
    localparam int IDX_W = $clog2(HDR_BITS);
    localparam int REP_W = $clog2(REP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HDR  = 2'd2,
        HEC  = 2'd3
    } state_t;

endpackage

// File: rtl/bt_hdr_tx_seq_if.sv
// ----------------------------------------------------------------------------
// bt_hdr_tx_seq_if
// Link between the header sequencer and the HEC LFSR stage.
//   loadini_p  : load pulse, stage takes hecremini as its initial value
//   hecremini  : HEC initial value (latched UAP)
//   shift_in   : stage feeds hec_datin into the LFSR
//   shift_out  : stage shifts its remainder one place towards the MSB
//   datvalid_p : qualifier for either shift
//   hec_datin  : data bit for shift_in
//   hecrem     : current stage remainder, read back by the sequencer
// Modports: master = sequencer, slave = HEC stage.
// ----------------------------------------------------------------------------
interface bt_hdr_tx_seq_if;
    import bt_hdr_tx_seq_pkg::*;

    logic                loadini_p;
    logic [HEC_BITS-1:0] hecremini;
    logic                shift_in;
    logic                shift_out;
    logic                datvalid_p;
    logic                hec_datin;
    logic [HEC_BITS-1:0] hecrem;

    modport master (
        output loadini_p, hecremini, shift_in, shift_out, datvalid_p, hec_datin,
        input  hecrem
    );

    modport slave (
        input  loadini_p, hecremini, shift_in, shift_out, datvalid_p, hec_datin,
        output hecrem
    );

endinterface

// File: rtl/bt_rep_bitcnt.sv
// ----------------------------------------------------------------------------
// bt_rep_bitcnt
// Repetition counter chained to a logical bit index.
//   clk_6M   in  : system clock
//   rst      in  : asynchronous reset, active-high
//   bit_p    in  : count enable, one per transmitted repetition
//   clear    in  : synchronous clear of both counters (wins over bit_p)
//   rep_last out : current repetition is the last of the logical bit
//   bit_idx  out : logical bit index within the current phase
// ----------------------------------------------------------------------------
module bt_rep_bitcnt
    import bt_hdr_tx_seq_pkg::*;
(
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             bit_p,
    input  logic             clear,
    output logic             rep_last,
    output logic [IDX_W-1:0] bit_idx
);

    logic [REP_W-1:0] rep_cnt;

    assign rep_last = (rep_cnt == REP_W'(REP - 1));

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            rep_cnt <= '0;
            bit_idx <= '0;
        end else if (bit_p) begin
            if (rep_last) begin
                rep_cnt <= '0;
                bit_idx <= bit_idx + IDX_W'(1);
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end

endmodule

// File: rtl/bt_hdr_tx_seq.sv
// ----------------------------------------------------------------------------
// bt_hdr_tx_seq
// Transmit sequencer for the 18-bit Bluetooth packet header: 10 header bits
// (bit 0 first) followed by the 8-bit HEC (MSB first), each bit repeated
// REP times on the 1 Mbps bit strobe. It steers the external HEC LFSR stage
// through the hec interface and reads its remainder back.
//   clk_6M, rst     : 6 MHz clock, asynchronous active-high reset
//   start_p         : begin a sequence (ignored while busy)
//   abort_p         : abandon the running sequence (wins over everything)
//   bit_p           : 1 Mbps bit strobe
//   hdr_in, uap     : header word and HEC initial value, latched on start
//   hec             : master side of the HEC stage link
//   tx_bit          : current serial bit
//   tx_bit_valid_p  : tx_bit is sent in this bit period
//   busy            : sequence in progress
//   done_p          : last of the 54 repetitions sent
// ----------------------------------------------------------------------------
module bt_hdr_tx_seq
    import bt_hdr_tx_seq_pkg::*;
(
    input  logic                 clk_6M,
    input  logic                 rst,
    input  logic                 start_p,
    input  logic                 abort_p,
    input  logic                 bit_p,
    input  logic [HDR_BITS-1:0]  hdr_in,
    input  logic [HEC_BITS-1:0]  uap,
    bt_hdr_tx_seq_if.master      hec,
    output logic                 tx_bit,
    output logic                 tx_bit_valid_p,
    output logic                 busy,
    output logic                 done_p
);

    state_t              state;
    state_t              state_nxt;
    logic [HDR_BITS-1:0] hdr_reg;
    logic [HEC_BITS-1:0] uap_reg;

    logic                cnt_en;
    logic                cnt_clr;
    logic                rep_last;
    logic [IDX_W-1:0]    bit_idx;

    logic                loadini_c;
    logic                shift_in_c;
    logic                shift_out_c;
    logic                hec_datin_c;

    bt_rep_bitcnt u_cnt (
        .clk_6M   (clk_6M),
        .rst      (rst),
        .bit_p    (cnt_en),
        .clear    (cnt_clr),
        .rep_last (rep_last),
        .bit_idx  (bit_idx)
    );

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Header and UAP are captured only when a sequence actually starts, so a
    // start_p arriving mid-sequence cannot disturb the bits being sent.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            hdr_reg <= '0;
            uap_reg <= '0;
        end else if (state == IDLE && start_p && !abort_p) begin
            hdr_reg <= hdr_in;
            uap_reg <= uap;
        end
    end

    // The HEC stage controls are combinational on bit_p so the LFSR advances
    // on the very edge that closes the third repetition.
    always_comb begin
        state_nxt      = state;
        cnt_en         = 1'b0;
        cnt_clr        = 1'b0;
        loadini_c      = 1'b0;
        shift_in_c     = 1'b0;
        shift_out_c    = 1'b0;
        hec_datin_c    = 1'b0;
        tx_bit         = 1'b0;
        tx_bit_valid_p = 1'b0;
        done_p         = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start_p && !abort_p) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                cnt_clr   = 1'b1;
                loadini_c = 1'b1;
                state_nxt = abort_p ? IDLE : HDR;
            end

            HDR: begin
                tx_bit = hdr_reg[bit_idx];
                if (abort_p) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_p) begin
                    tx_bit_valid_p = 1'b1;
                    cnt_en         = 1'b1;
                    if (rep_last) begin
                        shift_in_c  = 1'b1;
                        hec_datin_c = hdr_reg[bit_idx];
                        if (bit_idx == IDX_W'(HDR_BITS - 1)) begin
                            cnt_clr   = 1'b1;
                            state_nxt = HEC;
                        end
                    end
                end
            end

            HEC: begin
                tx_bit = hec.hecrem[HEC_BITS-1];
                if (abort_p) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_p) begin
                    tx_bit_valid_p = 1'b1;
                    cnt_en         = 1'b1;
                    if (rep_last) begin
                        shift_out_c = 1'b1;
                        if (bit_idx == IDX_W'(HEC_BITS - 1)) begin
                            done_p    = 1'b1;
                            cnt_clr   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end

            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy           = (state != IDLE);
    assign hec.loadini_p  = loadini_c;
    assign hec.hecremini  = uap_reg;
    assign hec.shift_in   = shift_in_c;
    assign hec.shift_out  = shift_out_c;
    assign hec.datvalid_p = shift_in_c | shift_out_c;
    assign hec.hec_datin  = hec_datin_c;

endmodule

// File: tb/tb_bt_hdr_tx_seq.sv
// ----------------------------------------------------------------------------
// tb_bt_hdr_tx_seq
// Directed bench for bt_hdr_tx_seq. A behavioural HEC LFSR stage sits on the
// slave side of the interface; a separate golden function computes the HEC
// of (uap, hdr) for comparison against the serial stream.
// ----------------------------------------------------------------------------
module tb_bt_hdr_tx_seq;
    import bt_hdr_tx_seq_pkg::*;

    logic       clk_6M = 1'b0;
    logic       rst    = 1'b1;
    logic       start_p = 1'b0;
    logic       abort_p = 1'b0;
    logic       bit_p   = 1'b0;
    logic [9:0] hdr_in  = '0;
    logic [7:0] uap     = '0;
    logic       tx_bit;
    logic       tx_bit_valid_p;
    logic       busy;
    logic       done_p;

    always #5 clk_6M = ~clk_6M;

    bt_hdr_tx_seq_if hec_if ();

    bt_hdr_tx_seq dut (
        .clk_6M         (clk_6M),
        .rst            (rst),
        .start_p        (start_p),
        .abort_p        (abort_p),
        .bit_p          (bit_p),
        .hdr_in         (hdr_in),
        .uap            (uap),
        .hec            (hec_if),
        .tx_bit         (tx_bit),
        .tx_bit_valid_p (tx_bit_valid_p),
        .busy           (busy),
        .done_p         (done_p)
    );

    // Generator D^8+D^7+D^5+D^2+D+1, data entering at the MSB end.
    function automatic logic [7:0] lfsr_step(input logic [7:0] r, input logic d);
        logic fb;
        fb = d ^ r[7];
        return {r[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
    endfunction

    function automatic logic [7:0] hec_golden(input logic [7:0] u, input logic [9:0] h);
        logic [7:0] r;
        r = u;
        for (int i = 0; i < 10; i++) r = lfsr_step(r, h[i]);
        return r;
    endfunction

    // Behavioural HEC stage
    logic [7:0] hec_reg;
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) hec_reg <= '0;
        else if (hec_if.loadini_p) hec_reg <= hec_if.hecremini;
        else if (hec_if.datvalid_p && hec_if.shift_in) hec_reg <= lfsr_step(hec_reg, hec_if.hec_datin);
        else if (hec_if.datvalid_p && hec_if.shift_out) hec_reg <= {hec_reg[6:0], 1'b0};
    end
    assign hec_if.hecrem = hec_reg;

    int checks = 0;
    int errors = 0;
    int ph = 0;
    int n_tx, n_si, n_so, n_dv, n_bad, n_load, n_done, done_at, load_at;
    logic [7:0] load_val;
    logic       busy_at_done, last_busy;
    logic       txs [0:63];
    logic [9:0] hdat;
    logic [9:0] got_hdr;
    logic [7:0] got_hec;
    logic       rep_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_tx = 0; n_si = 0; n_so = 0; n_dv = 0; n_bad = 0;
        n_load = 0; n_done = 0; done_at = -1; load_at = -1;
        load_val = '0; busy_at_done = 1'b0; hdat = '0;
        for (int i = 0; i < 64; i++) txs[i] = 1'b0;
    endtask

    // One clock: drive inputs, sample at negedge, step past the posedge.
    task automatic cyc(input logic st, input logic ab);
        start_p = st;
        abort_p = ab;
        bit_p   = (ph == 0);
        ph      = (ph == 5) ? 0 : ph + 1;
        @(negedge clk_6M);
        if (tx_bit_valid_p) begin
            if (n_tx < 64) txs[n_tx] = tx_bit;
            n_tx++;
        end
        if (hec_if.shift_in) begin
            if (n_si < 10) hdat[n_si] = hec_if.hec_datin;
            n_si++;
        end
        if (hec_if.shift_out) begin
            n_so++;
            if (hec_if.hec_datin) n_bad++;
        end
        if (hec_if.datvalid_p) n_dv++;
        if (hec_if.shift_in && hec_if.shift_out) n_bad++;
        if (hec_if.datvalid_p && !(hec_if.shift_in || hec_if.shift_out)) n_bad++;
        if (hec_if.loadini_p) begin
            n_load++; load_val = hec_if.hecremini; load_at = n_tx;
        end
        if (done_p) begin
            n_done++; done_at = n_tx; busy_at_done = busy;
        end
        last_busy = busy;
        @(posedge clk_6M);
        #1;
        start_p = 1'b0;
        abort_p = 1'b0;
        bit_p   = 1'b0;
    endtask

    task automatic start_seq(input logic [9:0] h, input logic [7:0] u);
        clr();
        hdr_in = h;
        uap    = u;
        cyc(1'b1, 1'b0);
    endtask

    task automatic run_to_done(input int restart_at, input logic [9:0] alt);
        int c;
        c = 0;
        while (n_done == 0 && c < 600) begin
            if (c == restart_at) begin
                hdr_in = alt;
                cyc(1'b1, 1'b0);
            end else begin
                cyc(1'b0, 1'b0);
            end
            c++;
        end
        check("seq_done_once", n_done, 1);
        cyc(1'b0, 1'b0);
    endtask

    task automatic analyse();
        rep_ok = 1'b1;
        for (int i = 0; i < 18; i++)
            if (txs[3*i] !== txs[3*i+1] || txs[3*i] !== txs[3*i+2]) rep_ok = 1'b0;
        for (int i = 0; i < 10; i++) got_hdr[i] = txs[3*i];
        for (int k = 0; k < 8; k++) got_hec[7-k] = txs[30+3*k];
    endtask

    initial begin
        int c;
        clr();
        // ---------------- reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_tx_bit", tx_bit, 0);
        check("rst_tx_valid", tx_bit_valid_p, 0);
        check("rst_done", done_p, 0);
        check("rst_loadini", hec_if.loadini_p, 0);
        check("rst_hecremini", hec_if.hecremini, 0);
        check("rst_datvalid", hec_if.datvalid_p, 0);
        @(posedge clk_6M); @(posedge clk_6M); #1;
        rst = 1'b0;

        // ---------------- all-zero header
        start_seq(10'h000, 8'h00);
        run_to_done(-1, 10'h000);
        analyse();
        check("z_load_cnt", n_load, 1);
        check("z_load_val", load_val, 8'h00);
        check("z_load_first", load_at, 0);
        check("z_tx_cnt", n_tx, 54);
        check("z_hdr_bits", got_hdr, 10'h000);
        check("z_hec_bits", got_hec, 8'h00);
        check("z_done_at", done_at, 54);
        check("z_busy_at_done", busy_at_done, 1);
        check("z_busy_after", last_busy, 0);
        check("z_si_cnt", n_si, 10);
        check("z_so_cnt", n_so, 8);

        // ---------------- header 2A5, uap 47
        start_seq(10'h2A5, 8'h47);
        run_to_done(-1, 10'h000);
        analyse();
        check("a_load_val", load_val, 8'h47);
        check("a_hec_datin", hdat, 10'h2A5);
        check("a_rep3", rep_ok, 1);
        check("a_hdr_bits", got_hdr, 10'h2A5);
        check("a_hec_bits", got_hec, hec_golden(8'h47, 10'h2A5));
        check("a_tx_cnt", n_tx, 54);
        check("a_si_cnt", n_si, 10);
        check("a_so_cnt", n_so, 8);
        check("a_dv_cnt", n_dv, 18);
        check("a_bad_ctrl", n_bad, 0);

        // ---------------- abort after 20th strobe (abort coincides with 21st)
        start_seq(10'h155, 8'h12);
        c = 0;
        while (n_tx < 20 && c < 400) begin
            cyc(1'b0, 1'b0);
            c++;
        end
        check("ab_reach20", n_tx, 20);
        while (ph != 0) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("ab_no_valid", n_tx, 20);
        cyc(1'b0, 1'b0);
        check("ab_busy", last_busy, 0);
        repeat (100) cyc(1'b0, 1'b0);
        check("ab_tx_after", n_tx, 20);
        check("ab_no_done", n_done, 0);
        check("ab_si_cnt", n_si, 6);

        start_seq(10'h0F0, 8'h3C);
        run_to_done(-1, 10'h000);
        analyse();
        check("ab2_load_first", load_at, 0);
        check("ab2_load_cnt", n_load, 1);
        check("ab2_tx_cnt", n_tx, 54);
        check("ab2_hdr_bits", got_hdr, 10'h0F0);
        check("ab2_hec_bits", got_hec, hec_golden(8'h3C, 10'h0F0));

        // ---------------- start re-pulsed mid-header
        start_seq(10'h1C3, 8'h81);
        run_to_done(100, 10'h3C5);
        analyse();
        check("rs_load_cnt", n_load, 1);
        check("rs_hdr_bits", got_hdr, 10'h1C3);
        check("rs_hec_datin", hdat, 10'h1C3);
        check("rs_hec_bits", got_hec, hec_golden(8'h81, 10'h1C3));
        check("rs_tx_cnt", n_tx, 54);

        // ---------------- asynchronous reset during HEC
        start_seq(10'h2A5, 8'h47);
        c = 0;
        while (n_tx < 36 && c < 400) begin
            cyc(1'b0, 1'b0);
            c++;
        end
        check("r_busy_pre", busy, 1);
        bit_p = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("r_busy", busy, 0);
        check("r_tx_bit", tx_bit, 0);
        check("r_tx_valid", tx_bit_valid_p, 0);
        check("r_done", done_p, 0);
        check("r_shift_out", hec_if.shift_out, 0);
        check("r_datvalid", hec_if.datvalid_p, 0);
        check("r_hecremini", hec_if.hecremini, 0);
        @(posedge clk_6M); @(posedge clk_6M); #1;
        rst   = 1'b0;
        bit_p = 1'b0;
        clr();
        repeat (30) cyc(1'b0, 1'b0);
        check("r_idle_busy", last_busy, 0);
        check("r_idle_tx", n_tx, 0);
        check("r_idle_load", n_load, 0);

        start_seq(10'h3FF, 8'hFF);
        run_to_done(-1, 10'h000);
        analyse();
        check("r2_tx_cnt", n_tx, 54);
        check("r2_hdr_bits", got_hdr, 10'h3FF);
        check("r2_hec_bits", got_hec, hec_golden(8'hFF, 10'h3FF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt_hdr_tx_seq.md
Name: bt_hdr_tx_seq

Overview:
Transmit-side sequencer for the 18-bit Bluetooth packet header: 10 header bits followed by an 8-bit HEC. It drives the control and data inputs of the HEC LFSR stage directly downstream (load, shift_in, shift_out, datvalid_p, hec_datin) and reads back its 8-bit remainder. It emits the header and HEC as a serial bit stream with rate-1/3 repetition (each bit sent 3 times, 54 bit periods total) towards the air-bit mux.

Parameters:
HDR_BITS, 10, header payload length (LT_ADDR 3, TYPE 4, FLOW, ARQN, SEQN)
HEC_BITS, 8, HEC length
REP, 3, repetition factor per logical bit

Ports:
clk_6M  in  1  6 MHz system clock
rst  in  1  asynchronous reset, active-high
start_p  in  1  one-cycle pulse: begin header transmission
abort_p  in  1  one-cycle pulse: abandon transmission
bit_p  in  1  one-cycle 1 Mbps bit strobe (1 of every 6 clocks)
hdr_in  in  10  header word, bit 0 sent first
uap  in  8  HEC initial value
hecrem  in  8  remainder from HEC stage
loadini_p  out  1  load pulse to HEC stage
hecremini  out  8  HEC init value (= latched uap)
shift_in  out  1  HEC stage: feed data bit
shift_out  out  1  HEC stage: shift remainder out
datvalid_p  out  1  HEC stage: shift qualifier
hec_datin  out  1  HEC stage: data bit
tx_bit  out  1  current serial bit
tx_bit_valid_p  out  1  strobe: tx_bit is sent this bit period
busy  out  1  sequence in progress
done_p  out  1  one-cycle pulse: 54th bit sent

Behaviour:
- Reset (async, rst=1): state IDLE, bit_idx=0, rep_cnt=0, hdr_reg=0, uap_reg=0. All outputs 0.
- FSM states: IDLE, LOAD, HDR, HEC.
- IDLE: start_p=1 latches hdr_in->hdr_reg and uap->uap_reg, then moves to LOAD. busy=0.
- LOAD: lasts exactly one cycle. loadini_p=1, hecremini=uap_reg, then moves to HDR with bit_idx=0 and rep_cnt=0. A bit_p in this cycle is ignored.
- HDR: tx_bit=hdr_reg[bit_idx], held constant across all 3 repetitions. On each bit_p: tx_bit_valid_p=1 and rep_cnt increments.
  - When bit_p arrives with rep_cnt=REP-1, in the same cycle: shift_in=1, datvalid_p=1, hec_datin=hdr_reg[bit_idx]. rep_cnt returns to 0 and bit_idx increments.
  - After the bit_idx=9 shift: go to HEC, bit_idx=0.
- HEC: tx_bit=hecrem[7] (MSB first). It is stable across the repetitions because the HEC stage only shifts on the third strobe.
  - On each bit_p: tx_bit_valid_p=1.
  - On the third repetition: shift_out=1, datvalid_p=1, hec_datin=0.
  - After the bit_idx=7 shift: done_p=1 in that same cycle, then IDLE.
- Control outputs toward the HEC stage (shift_in, shift_out, datvalid_p, hec_datin, tx_bit_valid_p) are combinational from state, rep_cnt and bit_p, so the LFSR updates on the same edge. loadini_p is decoded from the LOAD state.
- shift_in and shift_out are never asserted together; datvalid_p=1 only when one of them is 1.
- busy=1 in LOAD, HDR and HEC. tx_bit=0 when not in HDR or HEC.
- start_p while busy: ignored; the running sequence is unaffected.
- abort_p in any non-IDLE state: next state IDLE, counters cleared, no done_p, no HEC shift that cycle. abort_p has priority over bit_p. abort_p in IDLE: no effect.
- Simultaneous start_p and abort_p in IDLE: abort wins, stays IDLE.
- Reset mid-sequence: immediate return to the reset values. The HEC stage is re-initialised by the next LOAD.
- Total length: exactly 54 tx_bit_valid_p pulses, 10 shift_in pulses and 8 shift_out pulses per sequence.

Decomposition:
- Shared package: HDR_BITS, HEC_BITS, REP constants; state enum {IDLE, LOAD, HDR, HEC}.
- The repetition counter plus bit-index counter is a natural sub-module: bt_rep_bitcnt, with inputs bit_p and clear, and outputs rep_last and bit_idx.
- The HEC LFSR stage stays external and is instantiated alongside this block at top level.

Test Plan:
- hdr_in=10'h000, uap=8'h00, start_p, bit_p every 6 clks -> loadini_p once with hecremini=8'h00; 54 tx_bit_valid_p with tx_bit=0; done_p on the 54th; busy falls the next cycle.
- hdr_in=10'h2A5, uap=8'h47 -> hec_datin on the 10 shift_in pulses = 1,0,1,0,0,1,0,1,0,1; each tx_bit value repeated 3x; the 8 HEC tx_bits equal a golden-model HEC of (uap, hdr), MSB first.
- Pulse counting over one full sequence -> exactly 10 shift_in, 8 shift_out and 18 datvalid_p pulses; never shift_in and shift_out together.
- abort_p after the 20th bit_p -> IDLE next cycle, busy=0, no done_p, no further tx_bit_valid_p. A following start_p runs a complete 54-bit sequence starting with loadini_p.
- start_p re-pulsed during HDR with a different hdr_in -> ignored; the output stream matches the first header.
- rst asserted during HEC state -> all outputs 0 immediately (asynchronous); after release, state is IDLE until the next start_p.
